cycle_request_arbiter: RTL

CYCLE_REQUEST_ARBITER -- requirements
Module: cycle_request_arbiter

---
 rtl/cycle_request_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cycle_request_arbiter.sv
// Memory cycle request arbiter for command, parameter and inner-loop sources.
// Grants one source at a time, tracks the cycle handshake, and issues done pulses.
module cycle_request_arbiter #(
    parameter int unsigned INMAX = 4
) (
    input  logic       CCLK,
    input  logic       RESET,
    input  logic       COMRQ,
    input  logic       PARRQ,
    input  logic       INRQ,
    input  logic       ICYCST,
    input  logic       CYCEND,
    output logic       COMCRQ,
    output logic       PARCRQ,
    output logic       INCRQ,
    output logic       COMDN,
    output logic       PARDN,
    output logic       INDN,
    output logic [1:0] SRCSEL,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RUN
    } state_e;

    localparam logic [3:0] IN_MAX = INMAX[3:0];

    // Source vectors are ordered {inner, parameter, command}.
    state_e     state_q, state_d;
    logic [2:0] crq_q, crq_d;
    logic [2:0] dn_q, dn_d;
    logic [1:0] srcsel_q, srcsel_d;
    logic       busy_q, busy_d;
    logic [3:0] incnt_q, incnt_d;

    logic [2:0] req_raw;
    logic [2:0] req_arb;
    logic       prog_pend;
    logic       in_lock;
    logic [2:0] grant;
    logic [1:0] grant_sel;
    logic       owner_req;
    logic [2:0] owner_dn;

    // Arbitration: mask the source just completed, then inner > par > com,
    // with the inner source yielding once it has used up its grant budget.
    always_comb begin
        req_raw   = {INRQ, PARRQ, COMRQ};
        req_arb   = req_raw & ~dn_q;
        prog_pend = req_arb[1] | req_arb[0];
        in_lock   = (incnt_q == IN_MAX) && prog_pend;
        grant     = 3'b000;
        grant_sel = 2'd0;
        if (req_arb[2] && !in_lock) begin
            grant     = 3'b100;
            grant_sel = 2'd3;
        end else if (req_arb[1]) begin
            grant     = 3'b010;
            grant_sel = 2'd2;
        end else if (req_arb[0]) begin
            grant     = 3'b001;
            grant_sel = 2'd1;
        end
    end

    // Owner bookkeeping: is the owner still requesting, and which done to fire.
    always_comb begin
        owner_req = |(crq_q & req_raw);
        owner_dn  = 3'b000;
        unique case (srcsel_q)
            2'd1:    owner_dn = 3'b001;
            2'd2:    owner_dn = 3'b010;
            2'd3:    owner_dn = 3'b100;
            default: owner_dn = 3'b000;
        endcase
    end

    // Next-state and registered-output logic for IDLE/REQ/RUN.
    always_comb begin
        state_d  = state_q;
        crq_d    = crq_q;
        dn_d     = 3'b000;
        srcsel_d = srcsel_q;
        busy_d   = busy_q;
        incnt_d  = incnt_q;
        unique case (state_q)
            S_IDLE: begin
                crq_d    = 3'b000;
                srcsel_d = 2'd0;
                busy_d   = 1'b0;
                if (grant != 3'b000) begin
                    state_d  = S_REQ;
                    crq_d    = grant;
                    srcsel_d = grant_sel;
                    busy_d   = 1'b1;
                    if (grant[2]) begin
                        if (incnt_q < IN_MAX) begin
                            incnt_d = incnt_q + 4'd1;
                        end
                    end else begin
                        incnt_d = 4'd0;
                    end
                end
            end
            S_REQ: begin
                if (ICYCST) begin
                    state_d = S_RUN;
                    crq_d   = 3'b000;
                end else if (!owner_req) begin
                    state_d  = S_IDLE;
                    crq_d    = 3'b000;
                    srcsel_d = 2'd0;
                    busy_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (CYCEND) begin
                    state_d = S_IDLE;
                    dn_d    = owner_dn;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                crq_d    = 3'b000;
                srcsel_d = 2'd0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge CCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            crq_q    <= 3'b000;
            dn_q     <= 3'b000;
            srcsel_q <= 2'd0;
            busy_q   <= 1'b0;
            incnt_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            crq_q    <= crq_d;
            dn_q     <= dn_d;
            srcsel_q <= srcsel_d;
            busy_q   <= busy_d;
            incnt_q  <= incnt_d;
        end
    end

    assign COMCRQ = crq_q[0];
    assign PARCRQ = crq_q[1];
    assign INCRQ  = crq_q[2];
    assign COMDN  = dn_q[0];
    assign PARDN  = dn_q[1];
    assign INDN   = dn_q[2];
    assign SRCSEL = srcsel_q;
    assign BUSY   = busy_q;

endmodule
